m_key_conditioner: RTL and testbench
====================================

M_KEY_CONDITIONER -- requirements
Module: m_key_conditioner

Interface
REQ-001 SHALL have parameter TICK_DIV, default 27000: I_CLK cycles per sample tick (1 ms at 27 MHz).
REQ-002 SHALL have parameter DEB_LEN, default 6: consecutive equal tick samples needed to accept a key level change.
REQ-003 SHALL have parameter REPEAT_DLY, default 500: ticks a key is held before the first auto-repeat.
REQ-004 SHALL have parameter REPEAT_PER, default 100: ticks between auto-repeats; 0 disables auto-repeat.
REQ-005 SHALL have parameter DATA_INIT, default 8'hFF: reset value of O_DATA.
REQ-006 SHALL have port I_CLK, input, 1 bit: the single clock.
REQ-007 SHALL have port I_RESET, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port I_KEY_N, input, 1 bit: raw asynchronous push-button, low = pressed.
REQ-009 SHALL have port I_BUSY, input, 1 bit: SPI controller transfer in progress.
REQ-010 SHALL have port I_DONE, input, 1 bit: controller success level, synchronous to I_CLK.
REQ-011 SHALL have port O_START, output, 1 bit: one-cycle transfer start pulse to the controller.
REQ-012 SHALL have port O_DATA, output, 8 bits: byte to send to the slave.
REQ-013 SHALL have port O_KEY, output, 1 bit: debounced key state, 1 = pressed.
REQ-014 SHALL have port O_DROP, output, 1 bit: one-cycle pulse when a request merges into an already pending one.

Function
REQ-015 SHALL pass I_KEY_N through a 2-flop synchronizer before any other use.
REQ-016 SHALL pulse an internal tick for one cycle when its counter equals TICK_DIV-1, then wrap the counter to 0.
REQ-017 SHALL sample the synchronized key only on a tick.
REQ-018 SHALL toggle O_KEY only after DEB_LEN consecutive tick samples that all differ from the current O_KEY.
REQ-019 SHALL restart the stability count when any sample equals the current O_KEY.
REQ-020 SHALL run an FSM with states IDLE, HOLD and REPEAT.
REQ-021 SHALL, in IDLE, on O_KEY rising: raise a request, load the hold counter with REPEAT_DLY, and go to HOLD.
REQ-022 SHALL, in HOLD or REPEAT, decrement the hold counter once per tick.
REQ-023 SHALL, when the hold counter reaches 0 and REPEAT_PER is nonzero: raise a request, load REPEAT_PER, and go to or stay in REPEAT.
REQ-024 SHALL, when the hold counter reaches 0 and REPEAT_PER is 0: stay in HOLD with no further requests.
REQ-025 SHALL return to IDLE on O_KEY falling from any state, with no request.
REQ-026 SHALL set a single pending flag on each request.
REQ-027 SHALL pulse O_DROP for one cycle on a request while the flag is already set; the flag stays set.
REQ-028 SHALL drive O_START high for exactly one cycle in any cycle with pending=1 and I_BUSY=0, and clear pending in that cycle.
REQ-029 SHALL, when a request coincides with an O_START grant, leave pending set afterwards without asserting O_DROP.
REQ-030 SHALL decrement O_DATA by 1 modulo 256 (8'h00 -> 8'hFF) on a synchronous I_DONE rising edge, one cycle after the edge.
REQ-031 SHALL hold O_DATA constant otherwise.
REQ-032 SHALL size all counter widths from parameters with $clog2.

Reset
REQ-033 SHALL, on I_RESET high, set asynchronously: O_START=0, O_DROP=0, O_KEY=0, O_DATA=DATA_INIT, FSM=IDLE, pending=0, synchronizer flops=1 (released), all counters=0.
REQ-034 SHALL discard any request pending when reset asserts mid-operation.
REQ-035 SHALL require DEB_LEN new samples after reset release before O_KEY can assert.

Structure
REQ-036 SHALL place the FSM state enumeration and the default parameter constants in the shared package.
REQ-037 SHALL implement the tick divider, synchronizer and debouncer as one sub-module, m_key_debounce, instantiated once.

Verification (TICK_DIV=4, DEB_LEN=3, REPEAT_DLY=5, REPEAT_PER=2)
REQ-038 SHALL check: key low with 2-tick glitches -> O_KEY stays 0; key held low 3 ticks -> O_KEY=1, exactly one O_START.
REQ-039 SHALL check: key held 20 ticks, I_BUSY=0 -> first O_START at press, then one every 2 ticks starting 5 ticks after the first.
REQ-040 SHALL check: I_BUSY=1 during 3 requests -> 2 O_DROP pulses, then one O_START one cycle after I_BUSY falls.
REQ-041 SHALL check: 256 I_DONE pulses from reset -> O_DATA goes FF, FE, ..., 00, FF.
REQ-042 SHALL check: I_RESET asserted with pending=1 -> O_START never fires; all outputs at reset values immediately.
REQ-043 SHALL check: REPEAT_PER=0, key held 20 ticks -> exactly one O_START.

Source files
------------

// File: rtl/m_key_conditioner_pkg.sv
// Shared state encoding, default parameter values and counter sizing for the key conditioner.
package m_key_conditioner_pkg;

  localparam int unsigned TICK_DIV_DEF   = 27000;
  localparam int unsigned DEB_LEN_DEF    = 6;
  localparam int unsigned REPEAT_DLY_DEF = 500;
  localparam int unsigned REPEAT_PER_DEF = 100;
  localparam logic [7:0]  DATA_INIT_DEF  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Bits needed to hold 0..max_val; a zero-valued range still gets one bit.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/m_key_conditioner_if.sv
// Key conditioner to SPI controller signal bundle; master is the conditioner side.
interface m_key_conditioner_if;
  logic       I_KEY_N;
  logic       I_BUSY;
  logic       I_DONE;
  logic       O_START;
  logic [7:0] O_DATA;
  logic       O_KEY;
  logic       O_DROP;

  modport master (
    input  I_KEY_N, I_BUSY, I_DONE,
    output O_START, O_DATA, O_KEY, O_DROP
  );

  modport slave (
    output I_KEY_N, I_BUSY, I_DONE,
    input  O_START, O_DATA, O_KEY, O_DROP
  );
endinterface

// File: rtl/m_key_debounce.sv
// Synchronizes the raw active-low key, divides the clock into sample ticks and debounces on them.
// O_KEY lags a stable level change by DEB_LEN ticks plus the 2-flop synchronizer.
module m_key_debounce
  import m_key_conditioner_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned DEB_LEN  = DEB_LEN_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_tick,
  output logic o_key
);

  localparam int unsigned   TW        = cnt_w(TICK_DIV - 1);
  localparam int unsigned   DW        = cnt_w(DEB_LEN);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_LEN - 1);

  logic [1:0]    sync_q, sync_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [DW-1:0] stab_cnt_q, stab_cnt_d;
  logic          key_q, key_d;
  logic          tick;
  logic          sample;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q     <= 2'b11;
      tick_cnt_q <= '0;
      stab_cnt_q <= '0;
      key_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      tick_cnt_q <= tick_cnt_d;
      stab_cnt_q <= stab_cnt_d;
      key_q      <= key_d;
    end
  end

  always_comb begin
    sync_d     = {sync_q[0], i_key_n};
    sample     = ~sync_q[1];
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    stab_cnt_d = stab_cnt_q;
    key_d      = key_q;
    // Any sample agreeing with the accepted level restarts the run.
    if (tick) begin
      if (sample == key_q) begin
        stab_cnt_d = '0;
      end else if (stab_cnt_q == DEB_LAST) begin
        key_d      = sample;
        stab_cnt_d = '0;
      end else begin
        stab_cnt_d = stab_cnt_q + DW'(1);
      end
    end
  end

  assign o_tick = tick;
  assign o_key  = key_q;

endmodule

// File: rtl/m_key_conditioner.sv
// Turns a debounced push-button into SPI start requests with auto-repeat and a countdown data byte.
// Requests reach O_START one cycle after being granted; while I_BUSY is high one request is held and extras pulse O_DROP.
module m_key_conditioner
  import m_key_conditioner_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned DEB_LEN    = DEB_LEN_DEF,
  parameter int unsigned REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int unsigned REPEAT_PER = REPEAT_PER_DEF,
  parameter logic [7:0]  DATA_INIT  = DATA_INIT_DEF
) (
  input  logic                I_CLK,
  input  logic                I_RESET,
  m_key_conditioner_if.master bus
);

  localparam int unsigned   HOLD_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned   HW       = cnt_w(HOLD_MAX);
  localparam logic [HW-1:0] HOLD_DLY = HW'(REPEAT_DLY);
  localparam logic [HW-1:0] HOLD_PER = HW'(REPEAT_PER);
  localparam bit            RPT_EN   = (REPEAT_PER != 0);

  logic tick;
  logic key;

  m_key_debounce #(
    .TICK_DIV (TICK_DIV),
    .DEB_LEN  (DEB_LEN)
  ) u_debounce (
    .i_clk   (I_CLK),
    .i_rst   (I_RESET),
    .i_key_n (bus.I_KEY_N),
    .o_tick  (tick),
    .o_key   (key)
  );

  state_t        state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          key_dly_q, key_dly_d;
  logic          done_dly_q, done_dly_d;
  logic          pending_q, pending_d;
  logic          start_q, start_d;
  logic          drop_q, drop_d;
  logic [7:0]    data_q, data_d;
  logic          key_rise, key_fall, hold_expired, req, grant;

  assign key_rise     = key & ~key_dly_q;
  assign key_fall     = ~key & key_dly_q;
  // Expiry is judged on the tick that would take the counter to zero.
  assign hold_expired = tick && (hold_cnt_q <= HW'(1));

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (key_rise) state_d = ST_HOLD;
      end
      ST_HOLD, ST_REPEAT: begin
        if (key_fall)                    state_d = ST_IDLE;
        else if (hold_expired && RPT_EN) state_d = ST_REPEAT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req        = 1'b0;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (key_rise) begin
          req        = 1'b1;
          hold_cnt_d = HOLD_DLY;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (key_fall) begin
          hold_cnt_d = '0;
        end else if (hold_expired && RPT_EN) begin
          req        = 1'b1;
          hold_cnt_d = HOLD_PER;
        end else if (tick && (hold_cnt_q != '0)) begin
          hold_cnt_d = hold_cnt_q - HW'(1);
        end
      end
      default: hold_cnt_d = '0;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      hold_cnt_q <= '0;
      key_dly_q  <= 1'b0;
      done_dly_q <= 1'b0;
      pending_q  <= 1'b0;
      start_q    <= 1'b0;
      drop_q     <= 1'b0;
      data_q     <= DATA_INIT;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      key_dly_q  <= key_dly_d;
      done_dly_q <= done_dly_d;
      pending_q  <= pending_d;
      start_q    <= start_d;
      drop_q     <= drop_d;
      data_q     <= data_d;
    end
  end

  // A request landing on the grant cycle re-arms pending instead of counting as a drop.
  always_comb begin
    grant      = pending_q & ~bus.I_BUSY;
    start_d    = grant;
    drop_d     = req & pending_q & ~grant;
    pending_d  = req | (pending_q & ~grant);
    key_dly_d  = key;
    done_dly_d = bus.I_DONE;
    data_d     = (bus.I_DONE & ~done_dly_q) ? data_q - 8'd1 : data_q;
  end

  assign bus.O_START = start_q;
  assign bus.O_DROP  = drop_q;
  assign bus.O_KEY   = key;
  assign bus.O_DATA  = data_q;

endmodule

// File: tb/tb_m_key_conditioner.sv
// Randomized bench: tick-level reference model of debounce, repeat schedule and start/drop counts.
module tb_m_key_conditioner;

  localparam int unsigned TD  = 4;
  localparam int unsigned DEB = 3;
  localparam int unsigned DLY = 5;
  localparam int unsigned PER = 2;

  logic clk = 1'b0;
  logic rst;
  logic key_n;
  logic busy;
  logic done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  m_key_conditioner_if bus_a ();
  m_key_conditioner_if bus_z ();

  assign bus_a.I_KEY_N = key_n;
  assign bus_a.I_BUSY  = busy;
  assign bus_a.I_DONE  = done;
  assign bus_z.I_KEY_N = key_n;
  assign bus_z.I_BUSY  = 1'b0;
  assign bus_z.I_DONE  = done;

  m_key_conditioner #(
    .TICK_DIV(TD), .DEB_LEN(DEB), .REPEAT_DLY(DLY), .REPEAT_PER(PER), .DATA_INIT(8'hFF)
  ) dut_a (
    .I_CLK(clk), .I_RESET(rst), .bus(bus_a)
  );

  m_key_conditioner #(
    .TICK_DIV(TD), .DEB_LEN(DEB), .REPEAT_DLY(DLY), .REPEAT_PER(0), .DATA_INIT(8'hFF)
  ) dut_z (
    .I_CLK(clk), .I_RESET(rst), .bus(bus_z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed start pulses tagged with the tick interval they appear in.
  int cur_step = 0;
  int st_a[$];
  int st_z[$];
  int drop_a = 0;
  int drop_z = 0;

  always @(posedge clk) begin
    #1;
    if (bus_a.O_START === 1'b1) st_a.push_back(cur_step);
    if (bus_z.O_START === 1'b1) st_z.push_back(cur_step);
    if (bus_a.O_DROP === 1'b1) drop_a++;
    if (bus_z.O_DROP === 1'b1) drop_z++;
  end

  // Reference model state, advanced once per sample tick.
  int   m_tick, m_run, m_press;
  logic m_deb;
  int   ex_a[$];
  int   ex_z[$];

  task automatic clear_q();
    st_a.delete(); st_z.delete(); ex_a.delete(); ex_z.delete();
    drop_a = 0; drop_z = 0;
  endtask

  task automatic model_reset();
    m_tick = 0; m_run = 0; m_press = 0; m_deb = 1'b0; cur_step = 0;
    clear_q();
  endtask

  // One tick interval with the key at a fixed level; a request at tick j shows up as a start in interval j+1.
  task automatic step(input bit pressed);
    cur_step = m_tick;
    key_n    = ~pressed;
    repeat (TD) @(negedge clk);
    if (m_deb && (m_tick - m_press) >= int'(DLY) && ((m_tick - m_press - int'(DLY)) % int'(PER)) == 0)
      ex_a.push_back(m_tick + 1);
    if (pressed != m_deb) begin
      m_run++;
      if (m_run == int'(DEB)) begin
        m_deb = pressed;
        m_run = 0;
        if (pressed) begin
          m_press = m_tick;
          ex_a.push_back(m_tick + 1);
          ex_z.push_back(m_tick + 1);
        end
      end
    end else begin
      m_run = 0;
    end
    check("o_key_a", 32'(bus_a.O_KEY), 32'(m_deb));
    check("o_key_z", 32'(bus_z.O_KEY), 32'(m_deb));
    m_tick++;
  endtask

  task automatic cmp_q(input string tag, input int got[$], input int exp[$]);
    check({tag, "_cnt"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check({tag, "_tick"}, 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic cmp_all(input string tag);
    cmp_q({tag, "_a"}, st_a, ex_a);
    cmp_q({tag, "_z"}, st_z, ex_z);
    check({tag, "_drop_a"}, 32'(drop_a), 32'd0);
    check({tag, "_drop_z"}, 32'(drop_z), 32'd0);
    clear_q();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, 32'(bus_a.O_START), 32'd0);
    check({tag, "_drop"},  32'(bus_a.O_DROP),  32'd0);
    check({tag, "_key"},   32'(bus_a.O_KEY),   32'd0);
    check({tag, "_data"},  32'(bus_a.O_DATA),  32'hFF);
    check({tag, "_data_z"}, 32'(bus_z.O_DATA), 32'hFF);
  endtask

  logic [7:0] exp_data;

  initial begin
    rst = 1'b0; key_n = 1'b1; busy = 1'b0; done = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst0");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Short glitches never reach the debounce length, then one clean 3-tick press.
    for (int g = 0; g < 6; g++) begin
      int n;
      n = $urandom_range(1, 2);
      for (int i = 0; i < n; i++) step(1'b1);
      n = $urandom_range(1, 2);
      for (int i = 0; i < n; i++) step(1'b0);
    end
    check("glitch_key", 32'(bus_a.O_KEY), 32'd0);
    check("glitch_starts", 32'(st_a.size()), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1);
    check("press_key", 32'(bus_a.O_KEY), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0);
    check("press_one_start", 32'(st_a.size()), 32'd1);
    cmp_all("press");

    // Long hold: press start, then first repeat 5 ticks later and every 2 ticks after.
    for (int i = 0; i < 20; i++) step(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0);
    check("hold_gap1", 32'((st_a.size() > 2) ? st_a[1] - st_a[0] : 0), 32'(DLY));
    check("hold_gap2", 32'((st_a.size() > 2) ? st_a[2] - st_a[1] : 0), 32'(PER));
    check("hold_per0_one", 32'(st_z.size()), 32'd1);
    cmp_all("hold");

    // Random press/release runs.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) begin
        int n;
        n = $urandom_range(1, 12);
        for (int i = 0; i < n; i++) step(1'b1);
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) step(1'b0);
      end
      for (int i = 0; i < 5; i++) step(1'b0);
      cmp_all("rand");
    end

    // Busy controller during three requests: two merge as drops, one start after busy falls.
    busy = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0);
    check("busy_reqs_model", 32'(ex_a.size()), 32'd3);
    check("busy_no_start", 32'(st_a.size()), 32'd0);
    check("busy_drops", 32'(drop_a), 32'd2);
    busy = 1'b0;
    @(posedge clk); #1;
    check("busy_start_hi", 32'(bus_a.O_START), 32'd1);
    @(posedge clk); #1;
    check("busy_start_lo", 32'(bus_a.O_START), 32'd0);
    @(negedge clk);
    check("busy_one_start", 32'(st_a.size()), 32'd1);
    check("busy_drops_end", 32'(drop_a), 32'd2);
    cmp_q("busy_z", st_z, ex_z);
    clear_q();

    // I_DONE rising edges count O_DATA down with wrap; pulse widths and gaps are random.
    exp_data = 8'hFF;
    for (int p = 0; p < 259; p++) begin
      int w;
      done = 1'b1;
      w = $urandom_range(1, 3);
      repeat (w) @(negedge clk);
      done = 1'b0;
      w = $urandom_range(1, 3);
      repeat (w) @(negedge clk);
      exp_data = exp_data - 8'd1;
      check("data_a", 32'(bus_a.O_DATA), 32'(exp_data));
      check("data_z", 32'(bus_z.O_DATA), 32'(exp_data));
    end

    // Reset with a request held pending behind a busy controller.
    busy  = 1'b1;
    key_n = 1'b0;
    repeat (24) @(negedge clk);
    check("pend_key", 32'(bus_a.O_KEY), 32'd1);
    check("pend_no_start", 32'(st_a.size()), 32'd0);
    rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    key_n = 1'b1;
    busy  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) step(1'b0);
    check("rst_no_start", 32'(st_a.size()), 32'd0);
    cmp_all("rst_after");

    // Key held through reset needs a full set of fresh samples.
    rst   = 1'b1;
    key_n = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1);
    step(1'b1);
    check("rel_key_early", 32'(bus_a.O_KEY), 32'd0);
    step(1'b1);
    check("rel_key_on", 32'(bus_a.O_KEY), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0);
    cmp_all("rel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
